// File: rtl/dmem_bridge_pkg.sv
// rtl/dmem_bridge_pkg.sv - shared types and constants for the data-memory bus bridge
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } dbus_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
  } dbus_req_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
  } dbus_resp_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/dbus_timeout_counter.sv
// rtl/dbus_timeout_counter.sv - saturating response-wait counter with expiry flag
module dbus_timeout_counter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned   CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Expires in the cycle whose increment would reach TIMEOUT, i.e. the TIMEOUT-th wait cycle.
  assign o_expired = i_enable && (r_count >= (LIMIT - 1'b1));

endmodule

// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - turns the core's single-cycle data access into a valid/ready bus
// transaction, stalling the core until the response and flagging sticky errors
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic        core_we,
  input  logic        core_re,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_rdata,
  output logic        err
);

  dbus_state_t r_state, w_state_next;
  dbus_req_t   r_req, w_req_next;
  logic [31:0] r_rdata, w_rdata_next;
  logic        r_err, w_err_next;
  logic        w_access, w_cnt_clear, w_cnt_en, w_expired;
  dbus_resp_t  w_resp;

  assign w_access = core_we | core_re;
  assign w_resp   = '{valid: bus_resp_valid, rdata: bus_rdata};

  dbus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .rst_n     (reset),
    .i_clear   (w_cnt_clear),
    .i_enable  (w_cnt_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_req   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_req   <= w_req_next;
      r_rdata <= w_rdata_next;
      r_err   <= w_err_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_req_next   = r_req;
    w_rdata_next = r_rdata;
    w_err_next   = r_err;
    w_cnt_clear  = 1'b0;
    w_cnt_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_access) begin
          if (core_addr[1:0] == 2'b00) begin
            // A store wins when both strobes are up.
            w_req_next   = '{addr: core_addr, wdata: core_wdata, we: core_we};
            w_state_next = REQ;
          end else begin
            w_err_next   = 1'b1;
            w_rdata_next = ERR_DATA;
            w_state_next = DONE;
          end
        end
      end
      REQ: begin
        if (bus_req_ready) begin
          w_cnt_clear  = 1'b1;
          w_state_next = RESP;
        end
      end
      RESP: begin
        w_cnt_en = 1'b1;
        if (w_resp.valid) begin
          if (!r_req.we) begin
            w_rdata_next = w_resp.rdata;
          end
          w_state_next = DONE;
        end else if (w_expired) begin
          w_err_next   = 1'b1;
          w_rdata_next = ERR_DATA;
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign core_stall    = w_access & (r_state != DONE);
  assign core_rdata    = r_rdata;
  assign err           = r_err;
  assign bus_req_valid = (r_state == REQ);
  assign bus_addr      = r_req.addr;
  assign bus_wdata     = r_req.wdata;
  assign bus_we        = r_req.we;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb/tb_dmem_bridge.sv - self-checking bench for dmem_bridge with a transaction-level model
module tb_dmem_bridge;

  localparam int          TMO = 4;
  localparam logic [31:0] ERR = 32'hBAD0_0BAD;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] core_addr = '0;
  logic [31:0] core_wdata = '0;
  logic        core_we = 1'b0;
  logic        core_re = 1'b0;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        bus_req_valid;
  logic        bus_req_ready = 1'b0;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_resp_valid = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        err;

  int          n_checks = 0;
  int          n_fail = 0;
  logic        m_err = 1'b0;
  logic [31:0] m_rdata = '0;

  always #5 clk = ~clk;

  dmem_bridge #(.TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
    .clk            (clk),
    .reset          (reset),
    .core_addr      (core_addr),
    .core_wdata     (core_wdata),
    .core_we        (core_we),
    .core_re        (core_re),
    .core_rdata     (core_rdata),
    .core_stall     (core_stall),
    .bus_req_valid  (bus_req_valid),
    .bus_req_ready  (bus_req_ready),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_we         (bus_we),
    .bus_resp_valid (bus_resp_valid),
    .bus_rdata      (bus_rdata),
    .err            (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Entered and left just after a rising edge; reset clears the model too.
  task automatic do_reset();
    reset = 1'b0;
    core_we = 1'b0;
    core_re = 1'b0;
    bus_req_ready = 1'b0;
    bus_resp_valid = 1'b0;
    #1;
    check("rst_valid", {31'b0, bus_req_valid}, 32'd0);
    check("rst_stall", {31'b0, core_stall}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_rdata", core_rdata, 32'd0);
    m_err = 1'b0;
    m_rdata = '0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One core access; the bus withholds ready for rdy_wait REQ cycles and answers
  // resp_dly cycles after acceptance (no answer at all if that exceeds the timeout).
  task automatic run_access(input string tag, input logic we, input logic re,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int rdy_wait, input int resp_dly, input logic [31:0] brdata);
    logic mis, timed_out, bus_ok;
    int   exp_stall, stall_n, valid_n, acc_cyc;
    mis       = (addr[1:0] != 2'b00);
    timed_out = !mis && (resp_dly > TMO);
    exp_stall = mis ? 1 : 2 + rdy_wait + (timed_out ? TMO : resp_dly);
    if (mis || timed_out) begin
      m_err   = 1'b1;
      m_rdata = ERR;
    end else if (!we) begin
      m_rdata = brdata;
    end
    core_we = we;
    core_re = re;
    core_addr = addr;
    core_wdata = wdata;
    stall_n = 0;
    valid_n = 0;
    acc_cyc = -1;
    bus_ok = 1'b1;
    for (int c = 0; c < 64; c++) begin
      if (c > 0) begin
        core_addr = $urandom;
        core_wdata = $urandom;
      end
      bus_resp_valid = (acc_cyc >= 0) && !timed_out && (c == acc_cyc + resp_dly);
      bus_rdata = bus_resp_valid ? brdata : $urandom;
      bus_req_ready = bus_req_valid ? (valid_n >= rdy_wait) : 1'($urandom);
      @(negedge clk);
      if (bus_req_valid) begin
        valid_n++;
        if (bus_addr !== addr || bus_wdata !== wdata || bus_we !== we) bus_ok = 1'b0;
        if (bus_req_ready && acc_cyc < 0) acc_cyc = c;
      end
      if (!core_stall) break;
      stall_n++;
      @(posedge clk);
      #1;
    end
    check({tag, "_stall_cycles"}, stall_n, exp_stall);
    check({tag, "_rdata"}, core_rdata, m_rdata);
    check({tag, "_err"}, {31'b0, err}, {31'b0, m_err});
    check({tag, "_req_cycles"}, valid_n, mis ? 0 : rdy_wait + 1);
    check({tag, "_req_stable"}, {31'b0, bus_ok}, 32'd1);
    @(posedge clk);
    #1;
    bus_resp_valid = 1'b0;
  endtask

  initial begin
    logic        we, re;
    logic [31:0] addr;
    @(posedge clk);
    #1;
    do_reset();

    run_access("load", 1'b0, 1'b1, 32'h0000_0100, 32'h0, 0, 2, 32'hCAFE_F00D);
    run_access("store_bp", 1'b1, 1'b0, 32'h0000_0020, 32'h1234_5678, 3, 1, 32'h0BAD_F00D);
    run_access("both_is_write", 1'b1, 1'b1, 32'h0000_0044, 32'h0F0F_0F0F, 1, 2, 32'h7777_7777);
    run_access("misaligned", 1'b0, 1'b1, 32'h0000_0102, 32'h0, 0, 1, 32'h1111_1111);

    do_reset();
    run_access("timeout", 1'b0, 1'b1, 32'h0000_0080, 32'h0, 0, TMO + 1, 32'h2222_2222);
    do_reset();
    run_access("resp_at_limit", 1'b0, 1'b1, 32'h0000_0084, 32'h0, 0, TMO, 32'h5A5A_1234);

    // Reset while waiting in RESP, then a stray response that must be ignored.
    core_re = 1'b1;
    core_we = 1'b0;
    core_addr = 32'h0000_0300;
    bus_req_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    do_reset();
    bus_resp_valid = 1'b1;
    bus_rdata = 32'h3333_3333;
    @(negedge clk);
    check("late_resp_stall", {31'b0, core_stall}, 32'd0);
    check("late_resp_valid", {31'b0, bus_req_valid}, 32'd0);
    @(posedge clk);
    #1;
    bus_resp_valid = 1'b0;
    check("late_resp_rdata", core_rdata, 32'd0);
    run_access("after_reset", 1'b0, 1'b1, 32'h0000_0304, 32'h0, 0, 1, 32'h4444_4444);

    run_access("b2b_load", 1'b0, 1'b1, 32'h0000_0400, 32'h0, 0, 1, 32'h5555_AAAA);
    run_access("b2b_store", 1'b1, 1'b0, 32'h0000_0404, 32'h9999_0000, 0, 1, 32'h6666_6666);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) do_reset();
      we = 1'($urandom);
      re = we ? 1'($urandom) : 1'b1;
      addr = $urandom;
      if ($urandom_range(0, 9) != 0) addr[1:0] = 2'b00;
      run_access("rand", we, re, addr, $urandom, $urandom_range(0, 3),
                 $urandom_range(1, TMO + 2), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        core_we = 1'b0;
        core_re = 1'b0;
        @(negedge clk);
        check("idle_stall", {31'b0, core_stall}, 32'd0);
        @(posedge clk);
        #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
